// File: rtl/lsrs_pkg.sv
// Shared types and constants for the link reset supervisor.
// Holds the clock/reset bundle, the channel state encoding and the
// backoff and synchroniser constants. Imported by every supervisor file.
package lsrs_pkg;

    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

    typedef enum logic [2:0] {
        S_PULSE  = 3'd0,
        S_WAIT   = 3'd1,
        S_LINKED = 3'd2,
        S_LOS    = 3'd3,
        S_FAULT  = 3'd4
    } lsrs_state_t;

    // Largest left shift applied to the timeout when backoff is enabled.
    localparam int BACKOFF_LIMIT = 4;

    // Flops per asynchronous status input.
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/link_reset_channel.sv
// One supervised link: input synchronisers, retry FSM and counters.
// Ports: ClkRs_ix (clk, sync active-high reset), tick (shared timing tick),
//   los/ready (async status), clear (sync fault clear),
//   link_reset/linked/fault flags, retry_cnt, state (lsrs_state_t).
// Option: LINK_RESET_SUPERVISOR_BACKOFF_EN doubles the timeout per retry.
module link_reset_channel
    import lsrs_pkg::*;
#(
    parameter int g_timeout_ticks = 2400,
    parameter int g_max_retries   = 8,
    parameter int g_pulse_len     = 16,
    localparam int RW = $clog2(g_max_retries + 1)
) (
    input  ckrs_t         ClkRs_ix,
    input  logic          tick,
    input  logic          los,
    input  logic          ready,
    input  logic          clear,
    output logic          link_reset,
    output logic          linked,
    output logic          fault,
    output logic [RW-1:0] retry_cnt,
    output logic [2:0]    state
);

    localparam int PW = (g_pulse_len > 1) ? $clog2(g_pulse_len) : 1;
`ifdef LINK_RESET_SUPERVISOR_BACKOFF_EN
    localparam int TW = $clog2(g_timeout_ticks + 1) + BACKOFF_LIMIT;
`else
    localparam int TW = $clog2(g_timeout_ticks + 1);
`endif
    localparam logic [PW-1:0] PULSE_LAST = PW'(g_pulse_len - 1);

    logic [SYNC_DEPTH-1:0] los_sync;
    logic [SYNC_DEPTH-1:0] ready_sync;
    logic                  los_s;
    logic                  ready_s;

    lsrs_state_t   state_q;
    logic [PW-1:0] pulse_cnt;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry_q;
    logic [TW-1:0] timeout_last;
    logic [RW:0]   retry_inc;
    logic          retry_full;

    always_ff @(posedge ClkRs_ix.clk) begin
        if (ClkRs_ix.reset) begin
            los_sync   <= '0;
            ready_sync <= '0;
        end else begin
            los_sync   <= {los_sync[SYNC_DEPTH-2:0], los};
            ready_sync <= {ready_sync[SYNC_DEPTH-2:0], ready};
        end
    end

    assign los_s   = los_sync[SYNC_DEPTH-1];
    assign ready_s = ready_sync[SYNC_DEPTH-1];

`ifdef LINK_RESET_SUPERVISOR_BACKOFF_EN
    logic [2:0] shift;

    always_comb begin
        shift = 3'(BACKOFF_LIMIT);
        if (int'(retry_q) < BACKOFF_LIMIT) begin
            shift = 3'(retry_q);
        end
    end

    assign timeout_last = (TW'(g_timeout_ticks) << shift) - TW'(1);
`else
    assign timeout_last = TW'(g_timeout_ticks - 1);
`endif

    // A channel re-entering WAIT after LOS keeps its count, so the
    // count can already sit at the limit; saturate instead of wrapping.
    assign retry_inc  = {1'b0, retry_q} + (RW + 1)'(1);
    assign retry_full = int'(retry_inc) >= g_max_retries;

    always_ff @(posedge ClkRs_ix.clk) begin
        if (ClkRs_ix.reset) begin
            state_q   <= S_PULSE;
            pulse_cnt <= '0;
            timer     <= '0;
            retry_q   <= '0;
        end else if (los_s) begin
            state_q   <= S_LOS;
            pulse_cnt <= '0;
            timer     <= '0;
        end else begin
            unique case (state_q)
                S_PULSE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state_q   <= S_WAIT;
                        pulse_cnt <= '0;
                        timer     <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + PW'(1);
                    end
                end
                S_WAIT: begin
                    if (ready_s) begin
                        state_q <= S_LINKED;
                        retry_q <= '0;
                    end else if (tick) begin
                        if (timer == timeout_last) begin
                            timer <= '0;
                            if (retry_full) begin
                                state_q <= S_FAULT;
                                retry_q <= RW'(g_max_retries);
                            end else begin
                                state_q <= S_PULSE;
                                retry_q <= retry_inc[RW-1:0];
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                S_LINKED: begin
                    if (!ready_s) begin
                        state_q <= S_PULSE;
                    end
                end
                S_LOS: begin
                    state_q <= S_PULSE;
                end
                S_FAULT: begin
                    if (clear) begin
                        state_q <= S_PULSE;
                        retry_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_PULSE;
                end
            endcase
        end
    end

    assign link_reset = (state_q == S_PULSE) || (state_q == S_LOS);
    assign linked     = (state_q == S_LINKED);
    assign fault      = (state_q == S_FAULT);
    assign retry_cnt  = retry_q;
    assign state      = state_q;

endmodule

// File: rtl/link_reset_supervisor.sv
// Multi-channel GBT/MGT link watchdog: shared tick plus one FSM per link.
// Ports: ClkRs_ix (clk, sync active-high reset), los_i/ready_i (async),
//   clear_i (sync), link_reset_o, linked_o, fault_o, any_fault_o,
//   retry_cnt_o, state_o. Option macro: LINK_RESET_SUPERVISOR_BACKOFF_EN.
module link_reset_supervisor
    import lsrs_pkg::*;
#(
    parameter int g_channels      = 1,
    parameter int g_tick_divider  = 120000,
    parameter int g_timeout_ticks = 2400,
    parameter int g_max_retries   = 8,
    parameter int g_pulse_len     = 16,
    localparam int RW = $clog2(g_max_retries + 1)
) (
    input  ckrs_t                            ClkRs_ix,
    input  logic [g_channels-1:0]            los_i,
    input  logic [g_channels-1:0]            ready_i,
    input  logic [g_channels-1:0]            clear_i,
    output logic [g_channels-1:0]            link_reset_o,
    output logic [g_channels-1:0]            linked_o,
    output logic [g_channels-1:0]            fault_o,
    output logic                             any_fault_o,
    output logic [g_channels-1:0][RW-1:0]    retry_cnt_o,
    output logic [g_channels-1:0][2:0]       state_o
);

    localparam int CW = (g_tick_divider > 1) ? $clog2(g_tick_divider) : 1;

    logic [CW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == CW'(g_tick_divider - 1));

    always_ff @(posedge ClkRs_ix.clk) begin
        if (ClkRs_ix.reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    for (genvar i = 0; i < g_channels; i++) begin : g_ch
        link_reset_channel #(
            .g_timeout_ticks(g_timeout_ticks),
            .g_max_retries  (g_max_retries),
            .g_pulse_len    (g_pulse_len)
        ) u_ch (
            .ClkRs_ix  (ClkRs_ix),
            .tick      (tick),
            .los       (los_i[i]),
            .ready     (ready_i[i]),
            .clear     (clear_i[i]),
            .link_reset(link_reset_o[i]),
            .linked    (linked_o[i]),
            .fault     (fault_o[i]),
            .retry_cnt (retry_cnt_o[i]),
            .state     (state_o[i])
        );
    end

    assign any_fault_o = |fault_o;

endmodule

// File: tb/tb_link_reset_supervisor.sv
// Self-checking bench for link_reset_supervisor (2 channels, short timing).
// Honours LINK_RESET_SUPERVISOR_BACKOFF_EN for the expected WAIT lengths.
module tb_link_reset_supervisor;
    import lsrs_pkg::*;

    localparam int NCH  = 2;
    localparam int DIV  = 10;
    localparam int TO   = 5;
    localparam int MAXR = 3;
    localparam int PL   = 4;
    localparam int RW   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ckrs_t ckrs;
    logic [NCH-1:0] los;
    logic [NCH-1:0] ready;
    logic [NCH-1:0] clear;
    logic [NCH-1:0] link_reset_o;
    logic [NCH-1:0] linked_o;
    logic [NCH-1:0] fault_o;
    logic           any_fault_o;
    logic [NCH-1:0][RW-1:0] retry_cnt_o;
    logic [NCH-1:0][2:0]    state_o;

    assign ckrs = '{clk: clk, reset: rst};

    link_reset_supervisor #(
        .g_channels     (NCH),
        .g_tick_divider (DIV),
        .g_timeout_ticks(TO),
        .g_max_retries  (MAXR),
        .g_pulse_len    (PL)
    ) dut (
        .ClkRs_ix    (ckrs),
        .los_i       (los),
        .ready_i     (ready),
        .clear_i     (clear),
        .link_reset_o(link_reset_o),
        .linked_o    (linked_o),
        .fault_o     (fault_o),
        .any_fault_o (any_fault_o),
        .retry_cnt_o (retry_cnt_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Cycle index: value k means "just after the k-th edge since release".
    int cyc = 0;
    always @(posedge clk) cyc = rst ? 0 : cyc + 1;

    typedef struct {
        int          cc;
        int          ch;
        lsrs_state_t st;
        int          rc;
        logic        af;
        string       nm;
    } exp_t;

    typedef struct {
        int          dc;
        logic [1:0]  rdy;
        logic [1:0]  lo;
        logic [1:0]  clr;
        exp_t        e;
    } row_t;

    row_t tbl[$];
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [1:0] cur_rdy = '0;
    logic [1:0] cur_los = '0;
    logic [1:0] cur_clr = '0;

    task automatic add(input int dc, input int cc, input int ch,
                       input lsrs_state_t st, input int rc,
                       input logic af, input string nm);
        row_t r;
        r.dc  = dc;
        r.rdy = cur_rdy;
        r.lo  = cur_los;
        r.clr = cur_clr;
        r.e   = '{cc: cc, ch: ch, st: st, rc: rc, af: af, nm: nm};
        tbl.push_back(r);
    endtask

    task automatic cmp(input exp_t e);
        logic er;
        logic el;
        logic ef;
        er = (e.st == S_PULSE) || (e.st == S_LOS);
        el = (e.st == S_LINKED);
        ef = (e.st == S_FAULT);
        checks++;
        if (state_o[e.ch] !== e.st || link_reset_o[e.ch] !== er ||
            linked_o[e.ch] !== el || fault_o[e.ch] !== ef ||
            retry_cnt_o[e.ch] !== RW'(e.rc) || any_fault_o !== e.af) begin
            errors++;
            $display("FAIL %s ch%0d cyc%0d: got st=%0d rst=%b lnk=%b flt=%b rc=%0d af=%b, want st=%0d rst=%b lnk=%b flt=%b rc=%0d af=%b",
                     e.nm, e.ch, cyc, state_o[e.ch], link_reset_o[e.ch],
                     linked_o[e.ch], fault_o[e.ch], retry_cnt_o[e.ch],
                     any_fault_o, e.st, er, el, ef, e.rc, e.af);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cc == cyc) begin
                    cmp(sb[i]);
                    sb.delete(i);
                end else if (sb[i].cc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s ch%0d: expectation for cyc%0d never sampled (now cyc%0d)",
                             sb[i].nm, sb[i].ch, sb[i].cc, cyc);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        int w1, w2, w3, e1, e2, e3, f, r, d, l, guard;
        los   = '0;
        ready = '0;
        clear = '0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            cmp('{cc: 0, ch: c, st: S_PULSE, rc: 0, af: 1'b0, nm: "reset_state"});
        end
        rst = 1'b0;

        w1 = TO;
        w2 = TO;
        w3 = TO;
`ifdef LINK_RESET_SUPERVISOR_BACKOFF_EN
        w2 = TO * 2;
        w3 = TO * 4;
`endif
        // WAIT always starts 4 cycles past a multiple of DIV here, so a
        // W-tick WAIT ends exactly 10*W cycles after the previous boundary.
        e1 = DIV * w1;
        e2 = e1 + DIV * w2;
        e3 = e2 + DIV * w3;
        f  = e3 + 1000;

        for (int c = 0; c < NCH; c++) begin
            add(0, PL - 1, c, S_PULSE, 0, 1'b0, "pulse_last");
            add(0, PL,     c, S_WAIT,  0, 1'b0, "pulse_len");
            add(0, e1 - 1, c, S_WAIT,  0, 1'b0, "wait1_end");
            add(0, e1,     c, S_PULSE, 1, 1'b0, "retry1");
            add(0, e1 + 3, c, S_PULSE, 1, 1'b0, "retry1_pulse");
            add(0, e1 + 4, c, S_WAIT,  1, 1'b0, "wait2_start");
            add(0, e2 - 1, c, S_WAIT,  1, 1'b0, "wait2_end");
            add(0, e2,     c, S_PULSE, 2, 1'b0, "retry2");
            add(0, e2 + 3, c, S_PULSE, 2, 1'b0, "retry2_pulse");
            add(0, e2 + 4, c, S_WAIT,  2, 1'b0, "wait3_start");
            add(0, e3 - 1, c, S_WAIT,  2, 1'b0, "wait3_end");
            add(0, e3,     c, S_FAULT, 3, 1'b1, "fault");
            add(0, f,      c, S_FAULT, 3, 1'b1, "fault_hold");
        end

        cur_clr = 2'b01;
        add(f, f + 1, 0, S_PULSE, 0, 1'b1, "clear_pulse");
        add(f, f + 1, 1, S_FAULT, 3, 1'b1, "clear_other");
        cur_clr = 2'b00;
        add(f + 1, f + 4, 0, S_PULSE, 0, 1'b1, "clear_pulse_last");
        add(f + 1, f + 5, 0, S_WAIT,  0, 1'b1, "clear_pulse_len");
        add(f + 1, f + 5, 1, S_FAULT, 3, 1'b1, "clear_other_hold");

        r = f + 32;
        cur_rdy = 2'b01;
        add(r, r + 2, 0, S_WAIT,   0, 1'b1, "ready_sync");
        add(r, r + 3, 0, S_LINKED, 0, 1'b1, "linked");
        d = r + 10;
        cur_rdy = 2'b00;
        add(d, d + 2, 0, S_LINKED, 0, 1'b1, "unready_sync");
        add(d, d + 3, 0, S_PULSE,  0, 1'b1, "unready_pulse");
        add(d, d + 6, 0, S_PULSE,  0, 1'b1, "unready_pulse_last");
        add(d, d + 7, 0, S_WAIT,   0, 1'b1, "unready_pulse_len");
        cur_rdy = 2'b01;
        add(d + 10, d + 13, 0, S_LINKED, 0, 1'b1, "relink");

        l = d + 20;
        cur_los = 2'b11;
        add(l, l + 2, 0, S_LINKED, 0, 1'b1, "los_sync_lnk");
        add(l, l + 2, 1, S_FAULT,  3, 1'b1, "los_sync_flt");
        add(l, l + 3, 0, S_LOS,    0, 1'b0, "los_from_linked");
        add(l, l + 3, 1, S_LOS,    3, 1'b0, "los_from_fault");
        cur_los = 2'b00;
        add(l + 10, l + 12, 0, S_LOS,    0, 1'b0, "los_hold");
        add(l + 10, l + 13, 0, S_PULSE,  0, 1'b0, "los_exit_lnk");
        add(l + 10, l + 13, 1, S_PULSE,  3, 1'b0, "los_exit_flt");
        add(l + 10, l + 16, 0, S_PULSE,  0, 1'b0, "los_pulse_last");
        add(l + 10, l + 17, 0, S_WAIT,   0, 1'b0, "los_pulse_len");
        add(l + 10, l + 17, 1, S_WAIT,   3, 1'b0, "los_retry_kept");
        add(l + 10, l + 18, 0, S_LINKED, 0, 1'b0, "los_relink");

        foreach (tbl[k]) begin
            guard = 0;
            while (cyc < tbl[k].dc && guard < 5000) begin
                @(negedge clk);
                guard++;
            end
            if (cyc != tbl[k].dc) begin
                checks++;
                errors++;
                $display("FAIL drive_%s: at cyc%0d, required cyc%0d",
                         tbl[k].e.nm, cyc, tbl[k].dc);
            end
            ready = tbl[k].rdy;
            los   = tbl[k].lo;
            clear = tbl[k].clr;
            sb.push_back(tbl[k].e);
        end

        guard = 0;
        while (sb.size() > 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations pending, required 0",
                     sb.size());
        end

        rst = 1'b1;
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            cmp('{cc: 0, ch: c, st: S_PULSE, rc: 0, af: 1'b0, nm: "mid_reset"});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
